// File: rtl/ctrl_pkg.sv
// Shared encodings for the instruction-sequencing control FSM: states, opcodes,
// condition codes, mux selects and a small instruction classifier.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_ALU_REG = 4'h0;
  localparam logic [3:0] OP_MEMJ    = 4'h4;
  localparam logic [3:0] OP_BCOND   = 4'hC;
  localparam logic [3:0] OP_LUI     = 4'hF;

  localparam logic [3:0] EXT_AND   = 4'h1;
  localparam logic [3:0] EXT_OR    = 4'h2;
  localparam logic [3:0] EXT_XOR   = 4'h3;
  localparam logic [3:0] EXT_ADD   = 4'h5;
  localparam logic [3:0] EXT_SUB   = 4'h9;
  localparam logic [3:0] EXT_CMP   = 4'hB;
  localparam logic [3:0] EXT_MOV   = 4'hD;
  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STOR  = 4'h4;
  localparam logic [3:0] EXT_JAL   = 4'h8;
  localparam logic [3:0] EXT_JCOND = 4'hC;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_HI = 4'h4, CC_LS = 4'h5, CC_GT = 4'h6, CC_LE = 4'h7,
    CC_FS = 4'h8, CC_FC = 4'h9, CC_LO = 4'hA, CC_HS = 4'hB,
    CC_LT = 4'hC, CC_GE = 4'hD, CC_UC = 4'hE, CC_NV = 4'hF
  } cond_t;

  localparam logic [1:0] PC_INC  = 2'd0;
  localparam logic [1:0] PC_DISP = 2'd1;
  localparam logic [1:0] PC_REG  = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  typedef enum logic [2:0] {
    IC_ALU_REG, IC_ALU_IMM, IC_BCOND, IC_JCOND,
    IC_JAL, IC_LOAD, IC_STOR, IC_ILLEGAL
  } iclass_t;

  // The same 4-bit code names an ALU op in the ext field (register form)
  // and in the op field (immediate form).
  function automatic logic is_alu_code(input logic [3:0] code);
    case (code)
      EXT_AND, EXT_OR, EXT_XOR, EXT_ADD,
      EXT_SUB, EXT_CMP, EXT_MOV: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic iclass_t classify(input logic [3:0] op, input logic [3:0] ext);
    if (op == OP_ALU_REG)
      return is_alu_code(ext) ? IC_ALU_REG : IC_ILLEGAL;
    if (op == OP_LUI || is_alu_code(op))
      return IC_ALU_IMM;
    if (op == OP_BCOND)
      return IC_BCOND;
    if (op == OP_MEMJ) begin
      case (ext)
        EXT_LOAD:  return IC_LOAD;
        EXT_STOR:  return IC_STOR;
        EXT_JAL:   return IC_JAL;
        EXT_JCOND: return IC_JCOND;
        default:   return IC_ILLEGAL;
      endcase
    end
    return IC_ILLEGAL;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch/jump condition evaluator: maps a 4-bit condition code and the
// processor status flags to a single take decision.
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [3:0]  cond,
  input  logic [15:0] psr,
  output logic        take
);

  logic c_f, l_f, f_f, z_f, n_f;
  logic unused_psr;

  assign c_f = psr[0];
  assign l_f = psr[2];
  assign f_f = psr[5];
  assign z_f = psr[6];
  assign n_f = psr[7];
  assign unused_psr = ^{psr[15:8], psr[4:3], psr[1]};

  always_comb begin
    case (cond_t'(cond))
      CC_EQ:   take = z_f;
      CC_NE:   take = !z_f;
      CC_CS:   take = c_f;
      CC_CC:   take = !c_f;
      CC_HI:   take = l_f;
      CC_LS:   take = !l_f;
      CC_GT:   take = n_f;
      CC_LE:   take = !n_f;
      CC_FS:   take = f_f;
      CC_FC:   take = !f_f;
      CC_LO:   take = !l_f && !z_f;
      CC_HS:   take = l_f || z_f;
      CC_LT:   take = !n_f && !z_f;
      CC_GE:   take = n_f || z_f;
      CC_UC:   take = 1'b1;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC [-> MEM] -> FETCH,
// with a sticky HALT for undefined instructions when enabled.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instr,
  input  logic [15:0] psr,
  input  logic        mem_ready,
  output logic        instr_en,
  output logic        pc_en,
  output logic        cmp_f_en,
  output logic        of_f_en,
  output logic        z_f_en,
  output logic [1:0]  pc_src,
  output logic        addr_src,
  output logic        mem_re,
  output logic        mem_we,
  output logic        rf_wr_en,
  output logic [1:0]  wb_src,
  output logic        alu_b_imm,
  output logic        halted
);

  state_t     state;
  iclass_t    iclass;
  logic [3:0] op;
  logic [3:0] ext;
  logic [3:0] alu_code;
  logic       take;
  logic       unused_rsrc;

  assign op          = instr[15:12];
  assign ext         = instr[7:4];
  assign iclass      = classify(op, ext);
  assign alu_code    = (iclass == IC_ALU_REG) ? ext : op;
  assign unused_rsrc = ^instr[3:0];

  cond_eval u_cond_eval (
    .cond (instr[11:8]),
    .psr  (psr),
    .take (take)
  );

  // NOTE: state is sequential, so it is updated only with non-blocking
  // assignments; the async reset aborts any EXEC/MEM cycle in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_FETCH;
    end else begin
      case (state)
        ST_FETCH:  if (mem_ready) state <= ST_DECODE;
        ST_DECODE: state <= (HALT_ON_ILLEGAL && iclass == IC_ILLEGAL) ? ST_HALT : ST_EXEC;
        ST_EXEC:   state <= (iclass == IC_LOAD || iclass == IC_STOR) ? ST_MEM : ST_FETCH;
        ST_MEM:    if (mem_ready) state <= ST_FETCH;
        ST_HALT:   state <= ST_HALT;
        default:   state <= ST_FETCH;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    instr_en  = 1'b0;
    pc_en     = 1'b0;
    cmp_f_en  = 1'b0;
    of_f_en   = 1'b0;
    z_f_en    = 1'b0;
    pc_src    = PC_INC;
    addr_src  = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    rf_wr_en  = 1'b0;
    wb_src    = WB_ALU;
    alu_b_imm = 1'b0;
    halted    = 1'b0;

    case (state)
      ST_FETCH: begin
        mem_re   = 1'b1;
        // Gated so a fetch completing while reset is held never loads the IR.
        instr_en = mem_ready && reset_n;
      end
      ST_EXEC: begin
        case (iclass)
          IC_ALU_REG, IC_ALU_IMM: begin
            pc_en     = 1'b1;
            alu_b_imm = (iclass == IC_ALU_IMM);
            if (alu_code == EXT_CMP) begin
              cmp_f_en = 1'b1;
              z_f_en   = 1'b1;
            end else begin
              rf_wr_en = 1'b1;
              of_f_en  = (alu_code == EXT_ADD || alu_code == EXT_SUB);
            end
          end
          IC_BCOND: begin
            pc_en  = 1'b1;
            pc_src = take ? PC_DISP : PC_INC;
          end
          IC_JCOND: begin
            pc_en  = 1'b1;
            pc_src = take ? PC_REG : PC_INC;
          end
          IC_JAL: begin
            pc_en    = 1'b1;
            pc_src   = PC_REG;
            rf_wr_en = 1'b1;
            wb_src   = WB_LINK;
          end
          IC_LOAD, IC_STOR: ;
          default: pc_en = 1'b1;
        endcase
      end
      ST_MEM: begin
        addr_src = 1'b1;
        mem_re   = (iclass == IC_LOAD);
        mem_we   = (iclass != IC_LOAD);
        if (mem_ready) begin
          pc_en    = 1'b1;
          rf_wr_en = (iclass == IC_LOAD);
          wb_src   = (iclass == IC_LOAD) ? WB_MEM : WB_ALU;
        end
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: stimulus queues the expected output vector
// for every cycle, a negedge monitor pops and compares both parameterisations.
module tb_control_fsm;

  typedef struct packed {
    logic       instr_en;
    logic       pc_en;
    logic       cmp_f_en;
    logic       of_f_en;
    logic       z_f_en;
    logic [1:0] pc_src;
    logic       addr_src;
    logic       mem_re;
    logic       mem_we;
    logic       rf_wr_en;
    logic [1:0] wb_src;
    logic       alu_b_imm;
    logic       halted;
  } outs_t;

  typedef struct {
    string name;
    outs_t e1;
    outs_t e0;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [15:0] instr;
  logic [15:0] psr;
  logic        mem_ready;

  logic       instr_en1, pc_en1, cmp_f_en1, of_f_en1, z_f_en1, addr_src1;
  logic       mem_re1, mem_we1, rf_wr_en1, alu_b_imm1, halted1;
  logic [1:0] pc_src1, wb_src1;
  logic       instr_en0, pc_en0, cmp_f_en0, of_f_en0, z_f_en0, addr_src0;
  logic       mem_re0, mem_we0, rf_wr_en0, alu_b_imm0, halted0;
  logic [1:0] pc_src0, wb_src0;

  outs_t act1, act0;
  exp_t  exp_q[$];
  exp_t  mon_e;
  int    n_cmp = 0;
  int    n_bad = 0;

  control_fsm #(.HALT_ON_ILLEGAL(1'b1)) dut_halt (
    .clk(clk), .reset_n(reset_n), .instr(instr), .psr(psr), .mem_ready(mem_ready),
    .instr_en(instr_en1), .pc_en(pc_en1), .cmp_f_en(cmp_f_en1), .of_f_en(of_f_en1),
    .z_f_en(z_f_en1), .pc_src(pc_src1), .addr_src(addr_src1), .mem_re(mem_re1),
    .mem_we(mem_we1), .rf_wr_en(rf_wr_en1), .wb_src(wb_src1), .alu_b_imm(alu_b_imm1),
    .halted(halted1)
  );

  control_fsm #(.HALT_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .reset_n(reset_n), .instr(instr), .psr(psr), .mem_ready(mem_ready),
    .instr_en(instr_en0), .pc_en(pc_en0), .cmp_f_en(cmp_f_en0), .of_f_en(of_f_en0),
    .z_f_en(z_f_en0), .pc_src(pc_src0), .addr_src(addr_src0), .mem_re(mem_re0),
    .mem_we(mem_we0), .rf_wr_en(rf_wr_en0), .wb_src(wb_src0), .alu_b_imm(alu_b_imm0),
    .halted(halted0)
  );

  assign act1 = {instr_en1, pc_en1, cmp_f_en1, of_f_en1, z_f_en1, pc_src1, addr_src1,
                 mem_re1, mem_we1, rf_wr_en1, wb_src1, alu_b_imm1, halted1};
  assign act0 = {instr_en0, pc_en0, cmp_f_en0, of_f_en0, z_f_en0, pc_src0, addr_src0,
                 mem_re0, mem_we0, rf_wr_en0, wb_src0, alu_b_imm0, halted0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order in messages: ie pe cf of zf pcs as re we rf wb imm h
  task automatic check(input string nm, input string which, input outs_t got, input outs_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s [%s]: got %b required %b", nm, which, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check(mon_e.name, "halt_dut", act1, mon_e.e1);
      check(mon_e.name, "nop_dut", act0, mon_e.e0);
      n_cmp++;
      if ((pc_en1 && instr_en1) || (mem_re1 && mem_we1) ||
          (pc_en0 && instr_en0) || (mem_re0 && mem_we0)) begin
        n_bad++;
        $display("FAIL %s exclusivity: got %b / %b", mon_e.name, act1, act0);
      end
    end
  end

  function automatic outs_t fet(input logic mr);
    outs_t o = '0;
    o.mem_re   = 1'b1;
    o.instr_en = mr;
    return o;
  endfunction

  function automatic outs_t ex(input logic rf, input logic of, input logic cz,
                               input logic [1:0] pcs, input logic [1:0] wb, input logic imm);
    outs_t o = '0;
    o.pc_en     = 1'b1;
    o.rf_wr_en  = rf;
    o.of_f_en   = of;
    o.cmp_f_en  = cz;
    o.z_f_en    = cz;
    o.pc_src    = pcs;
    o.wb_src    = wb;
    o.alu_b_imm = imm;
    return o;
  endfunction

  function automatic outs_t memo(input logic we, input logic done);
    outs_t o = '0;
    o.addr_src = 1'b1;
    o.mem_we   = we;
    o.mem_re   = !we;
    o.pc_en    = done;
    o.rf_wr_en = done && !we;
    o.wb_src   = (done && !we) ? 2'd1 : 2'd0;
    return o;
  endfunction

  function automatic outs_t hlt();
    outs_t o = '0;
    o.halted = 1'b1;
    return o;
  endfunction

  task automatic cyc(input string nm, input logic mr, input logic rn, input outs_t e1, input outs_t e0);
    exp_t t;
    @(posedge clk);
    #1;
    mem_ready = mr;
    reset_n   = rn;
    t.name = nm;
    t.e1   = e1;
    t.e0   = e0;
    exp_q.push_back(t);
  endtask

  task automatic do_reset(input string nm);
    cyc({nm, ":reset"}, 1'b1, 1'b0, fet(1'b0), fet(1'b0));
  endtask

  task automatic run_simple(input string nm, input logic [15:0] ins, input logic [15:0] p,
                            input outs_t exec_o);
    instr = ins;
    psr   = p;
    do_reset(nm);
    cyc({nm, ":fetch"}, 1'b1, 1'b1, fet(1'b1), fet(1'b1));
    cyc({nm, ":decode"}, 1'b0, 1'b1, '0, '0);
    cyc({nm, ":exec"}, 1'b0, 1'b1, exec_o, exec_o);
    cyc({nm, ":refetch"}, 1'b0, 1'b1, fet(1'b0), fet(1'b0));
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    instr     = 16'h0000;
    psr       = 16'h0000;

    // ADD R1,R2 with a fetch stalled for two cycles first
    instr = 16'h0152;
    do_reset("add");
    cyc("add:fetch_wait0", 1'b0, 1'b1, fet(1'b0), fet(1'b0));
    cyc("add:fetch_wait1", 1'b0, 1'b1, fet(1'b0), fet(1'b0));
    cyc("add:fetch", 1'b1, 1'b1, fet(1'b1), fet(1'b1));
    cyc("add:decode", 1'b0, 1'b1, '0, '0);
    cyc("add:exec", 1'b0, 1'b1, ex(1, 1, 0, 2'd0, 2'd0, 0), ex(1, 1, 0, 2'd0, 2'd0, 0));
    cyc("add:refetch", 1'b0, 1'b1, fet(1'b0), fet(1'b0));

    run_simple("add_first", 16'h0152, 16'h0000, ex(1, 1, 0, 2'd0, 2'd0, 0));
    run_simple("cmp",   16'h03B4, 16'h0000, ex(0, 0, 1, 2'd0, 2'd0, 0));
    run_simple("addi",  16'h5103, 16'h0000, ex(1, 1, 0, 2'd0, 2'd0, 1));
    run_simple("cmpi",  16'hB207, 16'h0000, ex(0, 0, 1, 2'd0, 2'd0, 1));
    run_simple("xori",  16'h3207, 16'h0000, ex(1, 0, 0, 2'd0, 2'd0, 1));
    run_simple("lui",   16'hF1AB, 16'h0000, ex(1, 0, 0, 2'd0, 2'd0, 1));
    run_simple("mov",   16'h01D2, 16'h0000, ex(1, 0, 0, 2'd0, 2'd0, 0));
    run_simple("beq_t", 16'hC005, 16'h0040, ex(0, 0, 0, 2'd1, 2'd0, 0));
    run_simple("beq_n", 16'hC005, 16'h0000, ex(0, 0, 0, 2'd0, 2'd0, 0));
    run_simple("blo_t", 16'hCA10, 16'h0000, ex(0, 0, 0, 2'd1, 2'd0, 0));
    run_simple("blo_n", 16'hCA10, 16'h0004, ex(0, 0, 0, 2'd0, 2'd0, 0));
    run_simple("bcs_t", 16'hC205, 16'h0001, ex(0, 0, 0, 2'd1, 2'd0, 0));
    run_simple("buc_t", 16'hCE05, 16'h0000, ex(0, 0, 0, 2'd1, 2'd0, 0));
    run_simple("jge_t", 16'h4DC3, 16'h0080, ex(0, 0, 0, 2'd2, 2'd0, 0));
    run_simple("jnv_n", 16'h4FC3, 16'hFFFF, ex(0, 0, 0, 2'd0, 2'd0, 0));
    run_simple("jal",   16'h4382, 16'h0000, ex(1, 0, 0, 2'd2, 2'd2, 0));

    // LOAD with two memory wait cycles: six cycles from fetch to completion
    instr = 16'h4304;
    psr   = 16'h0000;
    do_reset("load");
    cyc("load:fetch", 1'b1, 1'b1, fet(1'b1), fet(1'b1));
    cyc("load:decode", 1'b0, 1'b1, '0, '0);
    cyc("load:exec", 1'b0, 1'b1, '0, '0);
    cyc("load:mem_wait0", 1'b0, 1'b1, memo(0, 0), memo(0, 0));
    cyc("load:mem_wait1", 1'b0, 1'b1, memo(0, 0), memo(0, 0));
    cyc("load:mem_done", 1'b1, 1'b1, memo(0, 1), memo(0, 1));
    cyc("load:refetch", 1'b0, 1'b1, fet(1'b0), fet(1'b0));

    // STOR completing normally
    instr = 16'h4340;
    do_reset("stor");
    cyc("stor:fetch", 1'b1, 1'b1, fet(1'b1), fet(1'b1));
    cyc("stor:decode", 1'b0, 1'b1, '0, '0);
    cyc("stor:exec", 1'b0, 1'b1, '0, '0);
    cyc("stor:mem_done", 1'b1, 1'b1, memo(1, 1), memo(1, 1));
    cyc("stor:refetch", 1'b0, 1'b1, fet(1'b0), fet(1'b0));

    // STOR aborted by reset asserted mid-cycle while in MEM
    do_reset("stor_abort");
    cyc("stor_abort:fetch", 1'b1, 1'b1, fet(1'b1), fet(1'b1));
    cyc("stor_abort:decode", 1'b0, 1'b1, '0, '0);
    cyc("stor_abort:exec", 1'b0, 1'b1, '0, '0);
    cyc("stor_abort:mem_wait", 1'b0, 1'b1, memo(1, 0), memo(1, 0));
    cyc("stor_abort:reset_in_mem", 1'b1, 1'b0, fet(1'b0), fet(1'b0));
    cyc("stor_abort:after_reset", 1'b0, 1'b1, fet(1'b0), fet(1'b0));

    // Undefined opcode: sticky HALT on one instance, NOP on the other
    instr = 16'h7000;
    do_reset("illegal");
    cyc("illegal:fetch", 1'b1, 1'b1, fet(1'b1), fet(1'b1));
    cyc("illegal:decode", 1'b0, 1'b1, '0, '0);
    cyc("illegal:exec", 1'b1, 1'b1, hlt(), ex(0, 0, 0, 2'd0, 2'd0, 0));
    cyc("illegal:next", 1'b1, 1'b1, hlt(), fet(1'b1));
    cyc("illegal:sticky", 1'b1, 1'b1, hlt(), '0);
    instr = 16'h0152;
    cyc("illegal:sticky_new_instr", 1'b1, 1'b1, hlt(), ex(1, 1, 0, 2'd0, 2'd0, 0));
    do_reset("illegal_clear");
    cyc("illegal_clear:fetch", 1'b0, 1'b1, fet(1'b0), fet(1'b0));

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d entries pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
